// File: rtl/axi4_rd_arb_pkg.sv
// Shared state encoding, requester count and round-robin helper for the AXI4 read arbiter.
package axi4_rd_arb_pkg;

  localparam int ARB_NUM_REQ = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // With both eligible the requester that did not win last time goes next.
  function automatic logic rr_pick(input logic [1:0] elig, input logic last);
    if (elig == 2'b11) return ~last;
    return elig[1];
  endfunction

endpackage

// File: rtl/axi4_rd_arb_outst_cnt.sv
// Per-requester outstanding-read counter; registered count, at_max is a combinational compare.
// Simultaneous inc/dec holds the count; dec at zero and inc at MAX_OUTST both hold.
module axi4_rd_arb_outst_cnt #(
  parameter int MAX_OUTST = 8,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_max_o
);

  logic [CNT_W-1:0] count_q, count_d;

  assign count_o  = count_q;
  assign at_max_o = (count_q == CNT_W'(MAX_OUTST));

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !at_max_o) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Two-requester AXI4 read arbiter: one bubble cycle per AR (1 AR / 2 cycles), R routed combinationally by the ID MSB.
// Grant holds until the downstream handshake; requesters at MAX_OUTST are skipped. KVIPS_AXI4_RD_ARB_QOS_EN enables arqos priority.
module axi4_rd_arbiter
  import axi4_rd_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int MAX_OUTST = 8
) (
  input  logic              aclk,
  input  logic              areset,
  // requester 0
  input  logic [ID_W-1:0]   s0_arid,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  input  logic [2:0]        s0_arprot,
  input  logic [3:0]        s0_arqos,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [ID_W-1:0]   s0_rid,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  // requester 1
  input  logic [ID_W-1:0]   s1_arid,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  input  logic [2:0]        s1_arprot,
  input  logic [3:0]        s1_arqos,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [ID_W-1:0]   s1_rid,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  // downstream
  output logic [ID_W:0]     m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [2:0]        m_arprot,
  output logic [3:0]        m_arqos,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W:0]     m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [2:0]        prot;
    logic [3:0]        qos;
  } ar_t;

  ar_t                    ar [ARB_NUM_REQ];
  logic [ARB_NUM_REQ-1:0] arvalid, arready, at_max, elig, ar_inc, r_dec;
  logic [CNT_W-1:0]       cnt [ARB_NUM_REQ];

  arb_state_e state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;
  logic       pick;
  logic       r_sel;

  assign ar[0] = '{id: s0_arid, addr: s0_araddr, len: s0_arlen, size: s0_arsize,
                   burst: s0_arburst, prot: s0_arprot, qos: s0_arqos};
  assign ar[1] = '{id: s1_arid, addr: s1_araddr, len: s1_arlen, size: s1_arsize,
                   burst: s1_arburst, prot: s1_arprot, qos: s1_arqos};
  assign arvalid = {s1_arvalid, s0_arvalid};
  assign elig    = arvalid & ~at_max;

`ifdef KVIPS_AXI4_RD_ARB_QOS_EN
  always_comb begin
    pick = rr_pick(elig, last_q);
    if (elig == 2'b11) begin
      if (ar[0].qos > ar[1].qos)      pick = 1'b0;
      else if (ar[1].qos > ar[0].qos) pick = 1'b1;
    end
  end
`else
  assign pick = rr_pick(elig, last_q);
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    m_arvalid = 1'b0;
    arready   = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (|elig) begin
          gnt_d   = pick;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        m_arvalid      = arvalid[gnt_q];
        arready[gnt_q] = m_arready;
        if (arvalid[gnt_q] && m_arready) begin
          last_d  = gnt_q;
          state_d = ARB_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ARB_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign s0_arready = arready[0];
  assign s1_arready = arready[1];

  // Payload always follows the registered grant; only m_arvalid is gated by state.
  assign m_arid    = {gnt_q, ar[gnt_q].id};
  assign m_araddr  = ar[gnt_q].addr;
  assign m_arlen   = ar[gnt_q].len;
  assign m_arsize  = ar[gnt_q].size;
  assign m_arburst = ar[gnt_q].burst;
  assign m_arprot  = ar[gnt_q].prot;
  assign m_arqos   = ar[gnt_q].qos;

  assign r_sel     = m_rid[ID_W];
  assign s0_rvalid = m_rvalid & ~r_sel;
  assign s1_rvalid = m_rvalid &  r_sel;
  assign s0_rid    = m_rid[ID_W-1:0];
  assign s1_rid    = m_rid[ID_W-1:0];
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;
  assign m_rready  = r_sel ? s1_rready : s0_rready;

  assign ar_inc = arready & arvalid;
  assign r_dec  = {m_rvalid & m_rready & m_rlast &  r_sel,
                   m_rvalid & m_rready & m_rlast & ~r_sel};

  axi4_rd_arb_outst_cnt #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) u_cnt0 (
    .aclk     (aclk),
    .areset   (areset),
    .inc_i    (ar_inc[0]),
    .dec_i    (r_dec[0]),
    .count_o  (cnt[0]),
    .at_max_o (at_max[0])
  );

  axi4_rd_arb_outst_cnt #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) u_cnt1 (
    .aclk     (aclk),
    .areset   (areset),
    .inc_i    (ar_inc[1]),
    .dec_i    (r_dec[1]),
    .count_o  (cnt[1]),
    .at_max_o (at_max[1])
  );

  always_ff @(posedge aclk) begin
    if (!areset) begin
      assert (cnt[0] <= CNT_W'(MAX_OUTST));
      assert (cnt[1] <= CNT_W'(MAX_OUTST));
    end
  end

endmodule

// File: doc/axi4_rd_arbiter.md
AXI4_RD_ARBITER -- requirements
Module: axi4_rd_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named aclk and areset.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 64: read data width.
REQ-004 Parameter ID_W, default 4: upstream ID width; downstream ID width is ID_W+1.
REQ-005 Parameter MAX_OUTST, default 8: maximum outstanding reads per requester (range 1..255).
REQ-006 aclk  in  1  rising-edge clock for all logic.
REQ-007 areset  in  1  synchronous active-high reset.
REQ-008 s{0,1}_arid/araddr/arlen/arsize/arburst/arprot/arqos  in  ID_W/ADDR_W/8/3/2/3/4  requester AR payload.
REQ-009 s{0,1}_arvalid  in  1; s{0,1}_arready  out  1  requester AR handshake.
REQ-010 s{0,1}_rid/rdata/rresp/rlast  out  ID_W/DATA_W/2/1  requester R payload.
REQ-011 s{0,1}_rvalid  out  1; s{0,1}_rready  in  1  requester R handshake.
REQ-012 m_arid  out  ID_W+1; m_araddr/arlen/arsize/arburst/arprot/arqos  out  same widths as REQ-008  downstream AR.
REQ-013 m_arvalid  out  1; m_arready  in  1  downstream AR handshake.
REQ-014 m_rid  in  ID_W+1; m_rdata/rresp/rlast  in  DATA_W/2/1; m_rvalid  in  1; m_rready  out  1  downstream R.

Function
REQ-015 The AR FSM SHALL have states IDLE and GRANT; gnt (1 bit) and last (1 bit) SHALL be registers.
REQ-016 IDLE: if any eligible requester asserts arvalid, the FSM SHALL latch gnt and enter GRANT on the next edge; otherwise it remains in IDLE.
REQ-017 Eligible SHALL mean arvalid=1 and outstanding count < MAX_OUTST.
REQ-018 With both requesters eligible, gnt SHALL be the requester not equal to last (round-robin).
REQ-019 GRANT: m_arvalid SHALL equal s[gnt]_arvalid; m_ar* SHALL equal s[gnt]_ar*; m_arid SHALL be {gnt, s[gnt]_arid}; s[gnt]_arready SHALL equal m_arready; the other arready SHALL be 0.
REQ-020 GRANT with m_arvalid&&m_arready SHALL set last<=gnt and return to IDLE; grant SHALL never change before the handshake.
REQ-021 In IDLE, m_arvalid and both s_arready SHALL be 0; AR latency is therefore one bubble cycle minimum, and back-to-back throughput is one AR every 2 cycles.
REQ-022 R routing SHALL be combinational: sel=m_rid[ID_W]; s[sel]_rvalid=m_rvalid; s[sel]_r* = m_r* with rid=m_rid[ID_W-1:0]; m_rready=s[sel]_rready; the other s_rvalid=0.
REQ-023 Per-requester outstanding counter ($clog2(MAX_OUTST+1) bits) SHALL increment on that requester's AR handshake and decrement on its R handshake with rlast=1.
REQ-024 Simultaneous increment and decrement SHALL leave the count unchanged; decrement at 0 SHALL saturate at 0; increment is impossible at MAX_OUTST due to REQ-017.
REQ-025 A requester at MAX_OUTST SHALL be skipped; the other requester SHALL be granted even if last selects it as lowest priority.

Reset
REQ-026 On areset: state=IDLE, gnt=0, last=1 (requester 0 wins first), counters=0; m_arvalid, s_arready, and registered outputs SHALL be 0 in the following cycle.
REQ-027 Reset asserted mid-GRANT SHALL abandon the grant without handshake; in-flight R beats after reset SHALL still route per REQ-022 with counters saturating per REQ-024.

Configuration
REQ-028 Macro KVIPS_AXI4_RD_ARB_QOS_EN defined: in IDLE the eligible requester with strictly higher arqos SHALL win, with equal arqos falling back to REQ-018.
REQ-029 Macro undefined: arqos SHALL be passed through only and arbitration SHALL be pure round-robin.

Structure
REQ-030 Package axi4_rd_arb_pkg SHALL hold the state enum (ARB_IDLE, ARB_GRANT) and the requester-count localparam (2).
REQ-031 The outstanding counter SHALL be sub-module axi4_rd_arb_outst_cnt (inc, dec, count, at_max), instantiated twice.

Verification
REQ-032 s0_arvalid alone, araddr=0x100, arid=3 -> m_arvalid at cycle 2, m_arid=0x03, s0_arready=m_arready.
REQ-033 s0 and s1 continuously valid after reset -> grants s0,s1,s0,s1 with m_arid MSB alternating.
REQ-034 m_rid=0x15, m_rvalid=1, rlast=1 -> s1_rvalid=1, s1_rid=5, s0_rvalid=0, s1 count decrements by 1.
REQ-035 MAX_OUTST=2, s0 issues 2 reads with no R -> s0 masked, s1 granted next; s0 rlast returned -> s0 eligible again.
REQ-036 areset pulsed while GRANT with m_arready=0 -> next cycle m_arvalid=0, counts=0, first new grant goes to s0.
REQ-037 KVIPS_AXI4_RD_ARB_QOS_EN, s0 arqos=2, s1 arqos=9, both valid -> s1 granted; equal arqos -> round-robin.
